bram_fifo_ctrl: RTL and testbench
=================================

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 ADDR_BITS, default 8, sets BRAM address width; FIFO depth DEPTH = 2**ADDR_BITS SHALL be supported.
REQ-002 DATA_BITS, default 64, SHALL set the width of every data port.
REQ-003 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous request to empty the FIFO and clear the BRAM.
REQ-006 in_valid  input  1  write-side data offered.
REQ-007 in_ready  output  1  write-side space available.
REQ-008 in_data  input  DATA_BITS  write-side data.
REQ-009 out_valid  output  1  read-side head entry valid.
REQ-010 out_ready  input  1  read-side consumer accepts.
REQ-011 out_data  output  DATA_BITS  head entry; SHALL be wired directly from bram_rd_data.
REQ-012 level  output  ADDR_BITS+1  number of stored entries, 0..DEPTH.
REQ-013 bram_clear  output  1  drives BRAM clear.
REQ-014 bram_rd_addr  output  ADDR_BITS  drives BRAM read address.
REQ-015 bram_wr_en, bram_wr_addr, bram_wr_data  output  1/ADDR_BITS/DATA_BITS  drive BRAM write port.
REQ-016 bram_rd_data  input  DATA_BITS  BRAM registered read data, one-cycle latency, read-old-data on same-address collision.

Function
REQ-017 States SHALL be CLEAR and RUN; CLEAR lasts exactly one cycle, then goes to RUN unless flush=1, in which case it stays in CLEAR.
REQ-018 In CLEAR: bram_clear=1, in_ready=0, out_valid=0, bram_wr_en=0; wr_ptr, rd_ptr and level SHALL be 0 on exit.
REQ-019 In RUN, flush=1 SHALL go to CLEAR next cycle; push and pop in that cycle are suppressed (in_ready=0, out_valid forced 0 combinationally).
REQ-020 Push fires when in_valid && in_ready; pop fires when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 in RUN iff level < DEPTH and flush=0; no write-through when full, even if a pop fires the same cycle.
REQ-022 On push: bram_wr_en=1, bram_wr_addr=wr_ptr, bram_wr_data=in_data; wr_ptr increments modulo DEPTH (natural wrap).
REQ-023 On pop: rd_ptr increments modulo DEPTH.
REQ-024 bram_rd_addr SHALL be rd_ptr_next = rd_ptr + pop, combinationally, every cycle.
REQ-025 level_next = level + push - pop; simultaneous push and pop SHALL leave level unchanged.
REQ-026 out_valid SHALL be a register: out_valid_next = (level_next != 0) && !(push && wr_ptr == rd_ptr_next) && next state is RUN.
REQ-027 Latency: a word pushed into an empty FIFO at edge N SHALL produce out_valid=1 after edge N+1 (two cycles), with out_data equal to that word.
REQ-028 A stale read (push to the address being read) SHALL drop out_valid for exactly one cycle, then reassert with correct data.
REQ-029 out_data SHALL hold while out_valid=1 and out_ready=0.
REQ-030 Entry order SHALL be strict FIFO, with no loss or duplication across pointer wrap.

Reset
REQ-031 While reset_n=0: state=CLEAR, wr_ptr=rd_ptr=0, level=0, out_valid=0, in_ready=0, bram_wr_en=0, bram_clear=1.
REQ-032 The first cycle after reset release SHALL be a CLEAR cycle, so BRAM contents are zero before any push.
REQ-033 Asserting reset mid-operation SHALL discard all entries asynchronously, with no partial write completing after the reset edge.

Verification (ADDR_BITS=2, DATA_BITS=8, paired with a BRAM of the team's standard behaviour)
REQ-034 Release reset, idle -> one cycle with bram_clear=1, then in_ready=1, out_valid=0, level=0.
REQ-035 Push 0x11 at edge N with out_ready=0 -> out_valid=1 after edge N+1, out_data=0x11, level=1.
REQ-036 Push 0xA0..0xA3 -> in_ready=0 and level=4; offer 0xA4 while popping -> 0xA4 not accepted; pops return A0,A1,A2,A3, then out_valid=0.
REQ-037 Streaming with out_ready=1 and 10 pushes -> pointers wrap twice, output sequence is identical and in order, level never exceeds 4.
REQ-038 level=1 with push and pop in the same cycle -> out_valid low for one cycle, then the new word appears, level stays 1.
REQ-039 flush with 3 entries stored -> no pop fires that cycle, one CLEAR cycle follows, then level=0 and out_valid=0; the next push returns its own data, not old data.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller around an external BRAM with registered read data
// A one-cycle CLEAR state wipes the BRAM; RUN serves push and pop.
module bram_fifo_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [ADDR_BITS:0]   level,
  output logic                 bram_clear,
  output logic [ADDR_BITS-1:0] bram_rd_addr,
  output logic                 bram_wr_en,
  output logic [ADDR_BITS-1:0] bram_wr_addr,
  output logic [DATA_BITS-1:0] bram_wr_data,
  input  logic [DATA_BITS-1:0] bram_rd_data
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(1) << ADDR_BITS;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS-1:0] w_rd_ptr_next;
  logic [ADDR_BITS:0]   r_level;
  logic [ADDR_BITS:0]   w_level_next;
  logic                 r_out_valid;
  logic                 w_run;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_stale;
  logic                 w_out_valid_next;

  assign w_run     = (r_state == ST_RUN);
  assign in_ready  = w_run && (r_level < DEPTH) && !flush;
  assign out_valid = r_out_valid && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_rd_ptr_next = r_rd_ptr + {{(ADDR_BITS-1){1'b0}}, w_pop};
  assign w_level_next  = r_level + {{ADDR_BITS{1'b0}}, w_push} - {{ADDR_BITS{1'b0}}, w_pop};
  assign w_state_next  = flush ? ST_CLEAR : ST_RUN;

  // Writing the slot being fetched returns old data next cycle, so hide it for one cycle.
  assign w_stale          = w_push && (r_wr_ptr == w_rd_ptr_next);
  assign w_out_valid_next = (w_level_next != '0) && !w_stale && (w_state_next == ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
      if (w_state_next == ST_CLEAR) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        r_rd_ptr <= w_rd_ptr_next;
        r_level  <= w_level_next;
      end
    end
  end

  assign level        = r_level;
  assign bram_clear   = !w_run;
  assign bram_rd_addr = w_rd_ptr_next;
  assign bram_wr_en   = w_push;
  assign bram_wr_addr = r_wr_ptr;
  assign bram_wr_data = in_data;
  assign out_data     = bram_rd_data;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed vector bench for bram_fifo_ctrl with a behavioural BRAM
module tb_bram_fifo_ctrl;

  localparam int AB = 2;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DB-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DB-1:0] out_data;
  logic [AB:0]   level;
  logic          bram_clear;
  logic [AB-1:0] bram_rd_addr;
  logic          bram_wr_en;
  logic [AB-1:0] bram_wr_addr;
  logic [DB-1:0] bram_wr_data;
  logic [DB-1:0] bram_rd_data;

  logic [DB-1:0] mem [0:(1<<AB)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .bram_clear   (bram_clear),
    .bram_rd_addr (bram_rd_addr),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_data (bram_rd_data)
  );

  // Registered read, read-old-data on collision, clear zeroes everything.
  always @(posedge clk) begin
    if (bram_clear) begin
      for (int k = 0; k < (1<<AB); k++) mem[k] <= '0;
      bram_rd_data <= '0;
    end else begin
      if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
      bram_rd_data <= mem[bram_rd_addr];
    end
  end

  typedef struct {
    bit          fl;
    bit          iv;
    logic [7:0]  id;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    bit          e_chk;
    logic [7:0]  e_od;
    logic [2:0]  e_lvl;
    bit          e_clr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int fl, input int iv, input int id, input int ordy,
                     input int ir, input int ov, input int chk, input int od,
                     input int lvl, input int clr);
    vec_t v;
    v.fl = fl[0]; v.iv = iv[0]; v.id = id[7:0]; v.ordy = ordy[0];
    v.e_ir = ir[0]; v.e_ov = ov[0]; v.e_chk = chk[0]; v.e_od = od[7:0];
    v.e_lvl = lvl[2:0]; v.e_clr = clr[0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    for (int k = 0; k < (1<<AB); k++) mem[k] = 8'hEE;
    bram_rd_data = 8'hEE;

    //  fl iv id    ordy ir ov chk od    lvl clr
    add(0, 0, 'h00, 0,   0, 0, 0, 'h00, 0, 1);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 1, 'h11, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 1, 0);
    add(0, 0, 'h00, 0,   1, 1, 1, 'h11, 1, 0);
    add(0, 0, 'h00, 1,   1, 1, 1, 'h11, 1, 0);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 1, 'hA0, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 1, 'hA1, 0,   1, 0, 0, 'h00, 1, 0);
    add(0, 1, 'hA2, 0,   1, 1, 1, 'hA0, 2, 0);
    add(0, 1, 'hA3, 0,   1, 1, 1, 'hA0, 3, 0);
    add(0, 1, 'hA4, 1,   0, 1, 1, 'hA0, 4, 0);
    add(0, 0, 'h00, 1,   1, 1, 1, 'hA1, 3, 0);
    add(0, 0, 'h00, 1,   1, 1, 1, 'hA2, 2, 0);
    add(0, 0, 'h00, 1,   1, 1, 1, 'hA3, 1, 0);
    add(0, 0, 'h00, 1,   1, 0, 0, 'h00, 0, 0);
    add(0, 1, 'hB0, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 1, 0);
    add(0, 0, 'h00, 0,   1, 1, 1, 'hB0, 1, 0);
    add(0, 1, 'hB1, 1,   1, 1, 1, 'hB0, 1, 0);
    add(0, 0, 'h00, 1,   1, 0, 0, 'h00, 1, 0);
    add(0, 0, 'h00, 0,   1, 1, 1, 'hB1, 1, 0);
    add(0, 1, 'hC0, 0,   1, 1, 1, 'hB1, 1, 0);
    add(0, 1, 'hC1, 0,   1, 1, 1, 'hB1, 2, 0);
    add(1, 1, 'hC2, 1,   0, 0, 0, 'h00, 3, 0);
    add(1, 0, 'h00, 0,   0, 0, 0, 'h00, 0, 1);
    add(0, 0, 'h00, 0,   0, 0, 0, 'h00, 0, 1);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 1, 'hD0, 0,   1, 0, 0, 'h00, 0, 0);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 1, 0);
    add(0, 0, 'h00, 1,   1, 1, 1, 'hD0, 1, 0);
    add(0, 0, 'h00, 0,   1, 0, 0, 'h00, 0, 0);

    #1;
    check("reset bram_clear", int'(bram_clear), 1);
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset level", int'(level), 0);
    check("reset bram_wr_en", int'(bram_wr_en), 0);

    @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
      check($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      check($sformatf("v%0d level", i), int'(level), int'(vecs[i].e_lvl));
      check($sformatf("v%0d bram_clear", i), int'(bram_clear), int'(vecs[i].e_clr));
      check($sformatf("v%0d bram_wr_en", i), int'(bram_wr_en), int'(vecs[i].iv & vecs[i].e_ir));
      if (vecs[i].e_chk) check($sformatf("v%0d out_data", i), int'(out_data), int'(vecs[i].e_od));
      @(negedge clk);
    end

    // Streaming through pointer wrap with the consumer always ready.
    sent = 0; rcv = 0; cyc = 0;
    flush = 1'b0;
    while (rcv < 10 && cyc < 100) begin
      in_valid = (sent < 10); in_data = 8'(8'h50 + sent); out_ready = 1'b1;
      #1;
      if (level > 3'd4) check("stream level bound", int'(level), 4);
      if (out_valid) begin
        check($sformatf("stream word %0d", rcv), int'(out_data), 'h50 + rcv);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    check("stream words received", rcv, 10);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("stream drained level", int'(level), 0);
    check("stream drained out_valid", int'(out_valid), 0);

    // Asynchronous reset in the middle of a push burst.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    in_data = 8'h78;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset level", int'(level), 0);
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset in_ready", int'(in_ready), 0);
    check("midreset bram_wr_en", int'(bram_wr_en), 0);
    check("midreset bram_clear", int'(bram_clear), 1);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-reset clear cycle", int'(bram_clear), 1);
    @(negedge clk);
    #1;
    check("post-reset in_ready", int'(in_ready), 1);
    check("post-reset level", int'(level), 0);
    check("post-reset out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
